alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Registered accumulator and result stage that sits directly downstream of the 16-bit XOR/XNOR logic units. It selects one unit result per accepted opcode, stores it in an accumulator, and presents the value through a valid/ready output register with status flags. The accumulator value is fed back as operand `a` of the logic units. This gives back-to-back chained logic operations with no external register.

## Interface
- `WIDTH`, default 16: datapath width; must match the logic units.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  opcode/operands valid.
- `in_ready`  out  1  stage can accept; combinational, `!out_valid || out_ready`.
- `opcode`  in  3  operation, enumerated in `alu_pkg`.
- `xor_result`  in  WIDTH  XOR unit output (`acc ^ b`).
- `xnor_result`  in  WIDTH  XNOR unit output (`~(acc ^ b)`).
- `load_data`  in  WIDTH  literal for LOAD.
- `acc`  out  WIDTH  accumulator; drives operand `a` of the logic units.
- `out_valid`  out  1  result beat valid.
- `out_ready`  in  1  consumer accepts beat.
- `out_data`  out  WIDTH  result beat.
- `flag_zero`  out  1  `out_data == 0`.
- `flag_parity`  out  1  XOR-reduction of `out_data`; present only with `ALU_PARITY_EN`.
- `flag_err`  out  1  sticky illegal-opcode flag.
- `beat_cnt`  out  8  count of output beats transferred.

## Operation
- Input transfer: `in_valid && in_ready` at the clock edge. Output transfer: `out_valid && out_ready`.
- Opcodes (all update `acc` on the accepting edge):
  - 000 NOP: `acc` unchanged, no output beat.
  - 001 CLR: `acc` = 0 and `flag_err` cleared; emits a beat.
  - 010 LOAD: `acc` = `load_data`; emits a beat.
  - 011 XOR: `acc` = `xor_result`; emits a beat.
  - 100 XNOR: `acc` = `xnor_result`; emits a beat.
  - 101 EMIT: `acc` unchanged; emits a beat carrying `acc`.
  - 110 and 111 are illegal: `acc` unchanged, `flag_err` set to 1, no beat.
- A beat loads `out_data` with the new `acc` value, sets `out_valid`, and registers the flags computed from that value.
- Output states:
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
  - EMPTY → FULL on a beat-producing accept.
  - FULL → EMPTY on an output transfer with no new beat in the same cycle.
  - FULL → FULL on an output transfer plus a new beat in the same cycle (register replaced, no bubble).
- While FULL and `!out_ready`: `out_data` and the flags hold stable, and `in_ready` = 0.
- `beat_cnt` increments on each output transfer and wraps 255 → 0. It is cleared only by reset.
- Widths: all results are exactly WIDTH bits; no extension or truncation.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - `acc` = 0, `out_valid` = 0, `out_data` = 0.
  - `flag_zero` = 0, `flag_parity` = 0, `flag_err` = 0, `beat_cnt` = 0.
  - `in_ready` is therefore 1.
- Latency: accept edge → `out_valid` and `acc` updated after that same edge (1 cycle).
- Throughput: one op per cycle while `out_ready` = 1. Because `acc` updates on the accept edge, the next op sees the updated operand `a`.
- Reset asserted mid-operation discards any pending beat. No output transfer is reported for it and `beat_cnt` does not count it.
- `in_valid` while `in_ready` = 0: the input is not consumed, and upstream must hold it.

## Configuration
- `ALU_PARITY_EN` defined: the `flag_parity` port and its register exist and are updated with each beat.
- Undefined: the port and register are omitted. All other behaviour is identical.

## Structure
- `alu_pkg` holds:
  - the 3-bit opcode enum (OP_NOP, OP_CLR, OP_LOAD, OP_XOR, OP_XNOR, OP_EMIT);
  - `ALU_WIDTH` = 16;
  - an `is_legal_op` function.
- One sub-module, `alu_flag_gen`: combinational zero/parity computation on the next-beat value.

## Test plan
- Reset released → `in_ready` = 1, all outputs 0. LOAD 0x00FF → next cycle `acc` = `out_data` = 0x00FF, `flag_zero` = 0, parity = 0.
- Back-to-back XOR, `out_ready` held at 1:
  - From `acc` 0x00FF, XOR with b = 0x0F0F → `out_data` 0x0FF0.
  - Next XOR with b = 0x0FF0 → `out_data` 0x0000, `flag_zero` = 1.
  - `beat_cnt` = 2.
- XNOR from `acc` 0x1234 with b = 0x1234 → `out_data` 0xFFFF, parity = 0.
- Backpressure:
  - With `out_ready` = 0 after EMIT of 0xABCD: `in_ready` = 0 and `out_data` stays 0xABCD for 5 cycles.
  - Raising `out_ready` with a queued LOAD 0x0001 → same-edge replacement, `out_valid` stays 1.
- Opcode 110 → `flag_err` = 1, no beat, `acc` unchanged. NOP → no change. CLR → `acc` = 0 and `flag_err` = 0.
- Assert `rst_n` low while FULL → all outputs 0 immediately. Also cover 256 transfers → `beat_cnt` wraps to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, output-register states, width and opcode helpers for the ALU result stage
package alu_pkg;
  localparam int ALU_WIDTH = 16;
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_XOR  = 3'd3,
    OP_XNOR = 3'd4,
    OP_EMIT = 3'd5
  } alu_op_e;
  typedef enum logic {ST_EMPTY, ST_FULL} out_state_e;
  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= OP_EMIT;
  endfunction
  function automatic logic emits_beat(input logic [2:0] op);
    return op != OP_NOP && is_legal_op(op);
  endfunction
endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: zero/parity flags of the next beat value; parity only with ALU_PARITY_EN
module alu_flag_gen #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  output logic             zero
`ifdef ALU_PARITY_EN
  , output logic           parity
`endif
);
  assign zero = data == '0;
`ifdef ALU_PARITY_EN
  assign parity = ^data;
`endif
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: accumulator plus valid/ready result register with flags and beat counter
// Optional flag_parity output and register exist only when ALU_PARITY_EN is defined.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] xor_result,
  input  logic [WIDTH-1:0] xnor_result,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             flag_zero,
`ifdef ALU_PARITY_EN
  output logic             flag_parity,
`endif
  output logic             flag_err,
  output logic [7:0]       beat_cnt
);
  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, out_data_q, out_data_d;
  logic             flag_zero_q, flag_zero_d, flag_err_q, flag_err_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic             accept, beat, out_xfer, nxt_zero;
`ifdef ALU_PARITY_EN
  logic             flag_parity_q, flag_parity_d, nxt_parity;
`endif

  assign out_valid = state_q == ST_FULL;
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign beat      = accept && emits_beat(opcode);
  assign out_xfer  = out_valid && out_ready;

  // flags are taken from the value the accumulator is about to hold
  alu_flag_gen #(.WIDTH(WIDTH)) u_flags (
    .data (acc_d),
    .zero (nxt_zero)
`ifdef ALU_PARITY_EN
    , .parity (nxt_parity)
`endif
  );

  always_comb begin
    state_d = state_q;
    if (beat) state_d = ST_FULL;
    else if (out_xfer) state_d = ST_EMPTY;
  end

  always_comb begin
    acc_d = !accept            ? acc_q :
            opcode == OP_CLR   ? '0 :
            opcode == OP_LOAD  ? load_data :
            opcode == OP_XOR   ? xor_result :
            opcode == OP_XNOR  ? xnor_result : acc_q;
    out_data_d  = beat ? acc_d : out_data_q;
    flag_zero_d = beat ? nxt_zero : flag_zero_q;
    flag_err_d  = !accept              ? flag_err_q :
                  !is_legal_op(opcode) ? 1'b1 :
                  opcode == OP_CLR     ? 1'b0 : flag_err_q;
    beat_cnt_d  = out_xfer ? beat_cnt_q + 8'd1 : beat_cnt_q;
  end

`ifdef ALU_PARITY_EN
  assign flag_parity_d = beat ? nxt_parity : flag_parity_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flag_parity_q <= 1'b0;
    else flag_parity_q <= flag_parity_d;
  assign flag_parity = flag_parity_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      acc_q       <= '0;
      out_data_q  <= '0;
      flag_zero_q <= 1'b0;
      flag_err_q  <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      flag_zero_q <= flag_zero_d;
      flag_err_q  <= flag_err_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign acc       = acc_q;
  assign out_data  = out_data_q;
  assign flag_zero = flag_zero_q;
  assign flag_err  = flag_err_q;
  assign beat_cnt  = beat_cnt_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed table plus backpressure, reset and counter-wrap sequences
module tb_alu_result_stage;
  import alu_pkg::*;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]  opcode = 3'd0;
  logic [15:0] x = 16'h0;
  logic [15:0] xor_result, xnor_result, acc, out_data;
  logic        in_ready, out_valid, flag_zero, flag_err;
  logic [7:0]  beat_cnt;
`ifdef ALU_PARITY_EN
  logic        flag_parity;
`endif
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  // stand-ins for the upstream XOR/XNOR units fed by the accumulator
  assign xor_result  = acc ^ x;
  assign xnor_result = ~(acc ^ x);

  alu_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .xor_result(xor_result), .xnor_result(xnor_result),
    .load_data(x), .acc(acc), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flag_zero(flag_zero),
`ifdef ALU_PARITY_EN
    .flag_parity(flag_parity),
`endif
    .flag_err(flag_err), .beat_cnt(beat_cnt)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] x;
    logic [15:0] acc;
    logic        vld;
    logic [15:0] dat;
    logic        z;
    logic        p;
    logic        e;
    logic [7:0]  cnt;
  } vec_t;
  vec_t v[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] a, input logic vl, input logic [15:0] d,
                         input logic z, input logic p, input logic e, input logic [7:0] c);
    chk({tag, ".acc"}, {16'h0, acc}, {16'h0, a});
    chk({tag, ".valid"}, {31'h0, out_valid}, {31'h0, vl});
    chk({tag, ".data"}, {16'h0, out_data}, {16'h0, d});
    chk({tag, ".zero"}, {31'h0, flag_zero}, {31'h0, z});
    chk({tag, ".err"}, {31'h0, flag_err}, {31'h0, e});
    chk({tag, ".cnt"}, {24'h0, beat_cnt}, {24'h0, c});
`ifdef ALU_PARITY_EN
    chk({tag, ".parity"}, {31'h0, flag_parity}, {31'h0, p});
`else
    if (p === 1'bx) chk({tag, ".parity_x"}, 32'h0, 32'h1);
`endif
  endtask

  initial begin
    v[0]  = '{OP_LOAD, 16'h00FF, 16'h00FF, 1, 16'h00FF, 0, 0, 0, 8'd0};
    v[1]  = '{OP_XOR,  16'h0F0F, 16'h0FF0, 1, 16'h0FF0, 0, 0, 0, 8'd1};
    v[2]  = '{OP_XOR,  16'h0FF0, 16'h0000, 1, 16'h0000, 1, 0, 0, 8'd2};
    v[3]  = '{OP_LOAD, 16'h1234, 16'h1234, 1, 16'h1234, 0, 1, 0, 8'd3};
    v[4]  = '{OP_XNOR, 16'h1234, 16'hFFFF, 1, 16'hFFFF, 0, 0, 0, 8'd4};
    v[5]  = '{3'b110,  16'h5A5A, 16'hFFFF, 0, 16'hFFFF, 0, 0, 1, 8'd5};
    v[6]  = '{OP_NOP,  16'h5A5A, 16'hFFFF, 0, 16'hFFFF, 0, 0, 1, 8'd5};
    v[7]  = '{OP_EMIT, 16'h0000, 16'hFFFF, 1, 16'hFFFF, 0, 0, 1, 8'd5};
    v[8]  = '{OP_CLR,  16'h1111, 16'h0000, 1, 16'h0000, 1, 0, 0, 8'd6};
    v[9]  = '{3'b111,  16'h2222, 16'h0000, 0, 16'h0000, 1, 0, 1, 8'd7};
    v[10] = '{OP_LOAD, 16'hABCD, 16'hABCD, 1, 16'hABCD, 0, 0, 1, 8'd7};
    v[11] = '{OP_EMIT, 16'h0000, 16'hABCD, 1, 16'hABCD, 0, 0, 1, 8'd8};

    #1;
    chk_all("rst_async", 16'h0, 0, 16'h0, 0, 0, 0, 8'd0);
    chk("rst.in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_all("rst_rel", 16'h0, 0, 16'h0, 0, 0, 0, 8'd0);
    chk("rel.in_ready", {31'h0, in_ready}, 32'h1);

    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      opcode = v[i].op;
      x = v[i].x;
      step();
      chk_all($sformatf("vec%0d", i), v[i].acc, v[i].vld, v[i].dat, v[i].z, v[i].p, v[i].e, v[i].cnt);
    end

    // EMIT 0xABCD is held; stall with a LOAD 0x0001 waiting upstream
    out_ready = 1'b0;
    opcode = OP_LOAD;
    x = 16'h0001;
    #1;
    chk("bp.in_ready", {31'h0, in_ready}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("bp%0d.in_ready", i), {31'h0, in_ready}, 32'h0);
      chk_all($sformatf("bp%0d", i), 16'hABCD, 1, 16'hABCD, 0, 0, 1, 8'd8);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release_ready", {31'h0, in_ready}, 32'h1);
    step();
    chk_all("replace", 16'h0001, 1, 16'h0001, 0, 1, 1, 8'd9);
    in_valid = 1'b0;
    step();
    chk_all("drain", 16'h0001, 0, 16'h0001, 0, 1, 1, 8'd10);

    // reset while FULL and stalled drops the beat
    in_valid = 1'b1;
    opcode = OP_LOAD;
    x = 16'h5555;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("full.valid", {31'h0, out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("rst_full", 16'h0, 0, 16'h0, 0, 0, 0, 8'd0);
    chk("rst_full.in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // 256 transfers wrap the beat counter
    in_valid = 1'b1;
    opcode = OP_LOAD;
    for (int i = 0; i < 256; i++) begin
      x = 16'(i);
      step();
    end
    chk("wrap.cnt255", {24'h0, beat_cnt}, 32'd255);
    in_valid = 1'b0;
    step();
    chk("wrap.cnt0", {24'h0, beat_cnt}, 32'd0);
    chk("wrap.valid", {31'h0, out_valid}, 32'h0);
    chk("wrap.acc", {16'h0, acc}, 32'h00FF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
